// File: rtl/alu_stage_pkg.sv
// Shared types for the ALU flag stage: condition codes, the NZCV flag layout,
// and the bit positions of each flag inside a 4-bit {n,z,c,v} vector.
package alu_stage_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_stage_cond_check.sv
// Combinational condition-code evaluator against a set of NZCV flags.
// Kept standalone so branch logic can reuse the same decode.
module cond_check
  import alu_stage_pkg::*;
(
  input  cond_t cond_i,
  input  nzcv_t flags_i,
  output logic  pass_o
);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    pass_o = 1'b1;
    case (cond_i)
      COND_EQ: pass_o =  flags_i.z;
      COND_NE: pass_o = !flags_i.z;
      COND_CS: pass_o =  flags_i.c;
      COND_CC: pass_o = !flags_i.c;
      COND_MI: pass_o =  flags_i.n;
      COND_PL: pass_o = !flags_i.n;
      COND_VS: pass_o =  flags_i.v;
      COND_VC: pass_o = !flags_i.v;
      COND_HI: pass_o =  flags_i.c && !flags_i.z;
      COND_LS: pass_o = !flags_i.c ||  flags_i.z;
      COND_GE: pass_o =  (flags_i.n == flags_i.v);
      COND_LT: pass_o =  (flags_i.n != flags_i.v);
      COND_GT: pass_o = !flags_i.z && (flags_i.n == flags_i.v);
      COND_LE: pass_o =  flags_i.z || (flags_i.n != flags_i.v);
      default: pass_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Post-ALU stage: owns the architectural NZCV register, predicates each beat
// on its condition code, and retires beats through a valid/ready skid output.
module alu_flag_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_nzcv,
  input  logic [3:0]       in_cond,
  input  logic             in_set_flags,
  input  logic [RADDR-1:0] in_rd,
  input  logic             in_wr_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RADDR-1:0] out_rd,
  output logic             out_wr,
  output logic             out_cond_pass,
  output logic [3:0]       flags_q
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RADDR-1:0] rd;
    logic             wr;
    logic             cond_pass;
  } beat_t;

  beat_t      in_beat, out_q, out_d, skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q;
  logic [3:0] flags_d;
  nzcv_t      cur_flags;
  logic       cond_pass, accept, out_fire;

  assign cur_flags = '{n: flags_q[FLAG_N], z: flags_q[FLAG_Z],
                       c: flags_q[FLAG_C], v: flags_q[FLAG_V]};

  cond_check u_cond_check (
    .cond_i  (cond_t'(in_cond)),
    .flags_i (cur_flags),
    .pass_o  (cond_pass)
  );

  assign accept   = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign in_beat  = '{result: in_result, rd: in_rd,
                      wr: in_wr_en && cond_pass, cond_pass: cond_pass};

  always_comb begin
    flags_d      = flags_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    // Flags commit at accept, independent of output backpressure.
    if (accept && cond_pass && in_set_flags) flags_d = in_nzcv;

    // in_ready is low while the skid is full, so no accept can race the drain.
    if (skid_valid_q && out_fire) begin
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || out_fire)) begin
      out_d       = in_beat;
      out_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all state, payload included, is async-reset so outputs read as zero the instant reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q      <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      flags_q      <= flags_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_q.result;
  assign out_rd        = out_q.rd;
  assign out_wr        = out_q.wr;
  assign out_cond_pass = out_q.cond_pass;

endmodule
